ifu_fetch_queue: RTL and testbench
==================================

# ifu_fetch_queue

Instruction-fetch front end. It owns the fetch PC register, issues word reads to instruction memory over a valid/ready request channel, and buffers in-order responses in a small queue feeding the decode stage. Redirects come from the next-PC logic in decode (branch/jump targets) and squash wrong-path fetches. The MIPS branch delay slot is optionally preserved.

## Interface
- `FIFO_DEPTH`, 2: buffered plus outstanding instruction capacity; power of two, ≥2.
- `RESET_PC`, 32'h00003000: fetch address after reset.

- `clk` in 1: clock, rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `redirect_valid` in 1: decode redirects fetch this cycle.
- `redirect_pc` in 32: redirect target; bits [1:0] ignored (forced 0).
- `imem_req_valid` out 1: fetch request present.
- `imem_req_ready` in 1: memory accepts the request this cycle.
- `imem_req_addr` out 32: word address of the request.
- `imem_rsp_valid` in 1: read data returned; one per accepted request, in order, ≥1 cycle after acceptance, no backpressure.
- `imem_rsp_data` in 32: instruction word.
- `if_valid` out 1: queue head is valid.
- `if_ready` in 1: decode consumes the head this cycle.
- `if_pc` out 32: PC of the head instruction.
- `if_instr` out 32: head instruction word.

## Operation
- Registers: `pc`, `run` flag, queue (pc+instr per entry, alloc/fill/read pointers), `drop_cnt`, and (macro on) `pend_valid`/`pend_pc`.
- `occ` = allocated entries (filled + outstanding) + `drop_cnt`. `deq` = `if_valid && if_ready`.
- `imem_req_valid` = `run && (occ - deq) < FIFO_DEPTH && !squash_now`. `imem_req_addr` = `pc`. The address may change while a request is unaccepted (after a redirect). Memory tolerates this.
- On acceptance: allocate the tail entry with pc, then `pc <= pc + 4` (32-bit wrap at 0xFFFFFFFC → 0).
- On response: if `drop_cnt`>0, decrement it and discard the data. Otherwise fill the oldest unfilled entry.
- `if_valid` = head entry filled. `if_pc`/`if_instr` come from the head. A deq pops the head.
- Redirect, no delay slot (`squash_now`=1): all entries are squashed. Outstanding unfilled entries are added to `drop_cnt`. `pc <= redirect_pc`. No request is issued in the redirect cycle. If deq occurs in the same cycle, that instruction is consumed normally.
- Simultaneous response and redirect: a response for a squashed request counts toward `drop_cnt` (dropped). A response for a preserved entry fills it.
- Redirect while `pend_valid`: the new target overwrites `pend_pc`.

## Timing
- Reset values: `pc`=RESET_PC, `run`=0, queue empty, `drop_cnt`=0, `pend_valid`=0. Outputs during reset: `imem_req_valid`=0, `if_valid`=0, `if_pc`=0, `if_instr`=0.
- `run` becomes 1 at the first rising edge after `reset_n` rises. The first request (addr RESET_PC) is presented in the following cycle.
- Latency: response in cycle t is visible on `if_valid` at t+1.
- Throughput: 1 instr/cycle with 1-cycle memory, FIFO_DEPTH=2, and `if_ready` held high.
- `imem_req_valid` has a combinational path from `if_ready`. `imem_req_ready` must not depend combinationally on `imem_req_valid`.
- Redirect in cycle t: the squashed head drops `if_valid` at t+1, and `imem_req_addr`=target at t+1.

## Configuration
- `IFU_DELAY_SLOT_EN` defined, redirect in cycle t:
  - The delay slot is the oldest instruction younger than the branch. If it is not dequeued in cycle t, it is preserved and only younger entries are squashed/dropped.
  - If the delay slot is not yet requested, `pc` (= branch+4) is fetched normally, `pend_pc` latches the target with `pend_valid`=1, and `pc <= pend_pc` once that request is accepted.
  - `squash_now`=0 whenever a preserved/pending delay slot still needs issuing.
- `IFU_DELAY_SLOT_EN` undefined: every redirect squashes everything not dequeued in cycle t. The `pend_*` registers are absent.

## Test plan
- Reset release, memory ready every cycle with 1-cycle latency, `if_ready`=1 → requests 0x3000, 0x3004, 0x3008… on consecutive cycles; `if_pc` 0x3000 one cycle after the first response; no bubbles.
- `if_ready`=0 for 5 cycles with FIFO_DEPTH=2 → at most 2 requests accepted, `imem_req_valid`=0, head holds 0x3000; resumes one issue per dequeue.
- Macro off, redirect to 0x4000 while 0x3008 is outstanding and 0x3004 is buffered → 0x3004 not delivered, 0x3008 response dropped, next `if_pc`=0x4000.
- Macro on, same stimulus → 0x3004 delivered, then 0x4000; 0x3008 dropped.
- Macro on, redirect to 0x5000 with the queue empty and pc=0x3010 → request 0x3010 then 0x5000; `if_pc` sequence 0x3010, 0x5000.
- `reset_n` low mid-stream with 2 outstanding → outputs cleared immediately; after release, late responses are not expected and the first request is 0x3000.

Source files
------------

// File: rtl/ifu_fetch_queue.sv
// Instruction-fetch front end: PC register, imem request channel and an in-order response queue.
// Define IFU_DELAY_SLOT_EN to keep the MIPS branch delay slot across redirects.
module ifu_fetch_queue #(
   parameter int          FIFO_DEPTH = 2,
   parameter logic [31:0] RESET_PC   = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam int CW = AW + 2;
   localparam logic [PW-1:0] P_ONE   = PW'(1);
   localparam logic [CW-1:0] C_ONE   = CW'(1);
   localparam logic [CW-1:0] C_DEPTH = CW'(FIFO_DEPTH);

   logic [31:0]   pc;
   logic [31:0]   target;
   logic          run;
   logic [31:0]   q_pc    [FIFO_DEPTH];
   logic [31:0]   q_instr [FIFO_DEPTH];
   logic [PW-1:0] alloc_ptr, fill_ptr, rd_ptr;
   logic [PW-1:0] d_alloc, d_unfilled;
   logic [CW-1:0] n_alloc, n_unfilled, young;
   logic [CW-1:0] occ, occ_after, rsp_cnt;
   // drop_late counts squashed responses that arrive after a preserved, still-unfilled head
   logic [CW-1:0] drop_cnt, drop_late;
   logic          deq, accept, rsp_drop, rsp_fill, head_filled;
   logic          full_sq, preserve, squash_now;

   assign d_alloc     = alloc_ptr - rd_ptr;
   assign d_unfilled  = alloc_ptr - fill_ptr;
   assign n_alloc     = {1'b0, d_alloc};
   assign n_unfilled  = {1'b0, d_unfilled};
   assign young       = n_unfilled - C_ONE;
   assign head_filled = (fill_ptr != rd_ptr);
   assign deq         = if_valid && if_ready;
   assign occ         = n_alloc + drop_cnt + drop_late;
   assign occ_after   = occ - {{(CW-1){1'b0}}, deq};
   assign rsp_cnt     = {{(CW-1){1'b0}}, imem_rsp_valid};
   assign rsp_drop    = imem_rsp_valid && (drop_cnt != '0);
   assign rsp_fill    = imem_rsp_valid && (drop_cnt == '0);
   assign target      = redirect_pc & 32'hFFFF_FFFC;

`ifdef IFU_DELAY_SLOT_EN
   logic        pend_valid;
   logic [31:0] pend_pc;
   logic        pend_case;

   // The head is the delay slot unless decode takes it in the redirect cycle.
   assign full_sq   = redirect_valid && deq;
   assign preserve  = redirect_valid && !deq && (n_alloc != '0);
   assign pend_case = redirect_valid && !deq && (n_alloc == '0);
`else
   assign full_sq  = redirect_valid;
   assign preserve = 1'b0;
`endif
   assign squash_now = full_sq || preserve;

   assign imem_req_valid = run && (occ_after < C_DEPTH) && !squash_now;
   assign imem_req_addr  = pc;
   assign accept         = imem_req_valid && imem_req_ready;

   assign if_valid = head_filled;
   assign if_pc    = head_filled ? q_pc[rd_ptr[AW-1:0]]    : '0;
   assign if_instr = head_filled ? q_instr[rd_ptr[AW-1:0]] : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         run       <= 1'b0;
         pc        <= RESET_PC;
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         rd_ptr    <= '0;
         drop_cnt  <= '0;
         drop_late <= '0;
`ifdef IFU_DELAY_SLOT_EN
         pend_valid <= 1'b0;
`endif
      end else begin
         run <= 1'b1;
         if (full_sq) begin
            alloc_ptr <= rd_ptr;
            fill_ptr  <= rd_ptr;
            drop_cnt  <= drop_cnt + drop_late + n_unfilled - rsp_cnt;
            drop_late <= '0;
            pc        <= target;
`ifdef IFU_DELAY_SLOT_EN
            pend_valid <= 1'b0;
`endif
         end else if (preserve) begin
            alloc_ptr <= rd_ptr + P_ONE;
            pc        <= target;
            if (head_filled) begin
               fill_ptr  <= rd_ptr + P_ONE;
               drop_cnt  <= drop_cnt + drop_late + n_unfilled - rsp_cnt;
               drop_late <= '0;
            end else if (rsp_fill) begin
               fill_ptr  <= rd_ptr + P_ONE;
               drop_cnt  <= drop_late + young;
               drop_late <= '0;
            end else begin
               if (rsp_drop)
                  drop_cnt <= drop_cnt - C_ONE;
               drop_late <= drop_late + young;
            end
`ifdef IFU_DELAY_SLOT_EN
            pend_valid <= 1'b0;
`endif
         end else begin
            if (accept)
               alloc_ptr <= alloc_ptr + P_ONE;
            if (rsp_fill) begin
               fill_ptr  <= fill_ptr + P_ONE;
               drop_cnt  <= drop_late;
               drop_late <= '0;
            end else if (rsp_drop) begin
               drop_cnt <= drop_cnt - C_ONE;
            end
            if (deq)
               rd_ptr <= rd_ptr + P_ONE;
`ifdef IFU_DELAY_SLOT_EN
            if (pend_case) begin
               if (accept)
                  pc <= target;
               pend_valid <= !accept;
            end else if (accept) begin
               pc         <= pend_valid ? pend_pc : pc + 32'd4;
               pend_valid <= 1'b0;
            end
`else
            if (accept)
               pc <= pc + 32'd4;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept)
         q_pc[alloc_ptr[AW-1:0]] <= pc;
      if (rsp_fill)
         q_instr[fill_ptr[AW-1:0]] <= imem_rsp_data;
`ifdef IFU_DELAY_SLOT_EN
      if (pend_case && !accept)
         pend_pc <= target;
`endif
   end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Randomized bench for ifu_fetch_queue: in-order memory model plus a program-order stream model.
module tb_ifu_fetch_queue;
   localparam int          DEPTH  = 2;
   localparam logic [31:0] RST_PC = 32'h0000_3000;

   logic        clk, reset_n, redirect_valid, imem_req_valid, imem_req_ready;
   logic        imem_rsp_valid, if_valid, if_ready;
   logic [31:0] redirect_pc, imem_req_addr, imem_rsp_data, if_pc, if_instr;

   ifu_fetch_queue #(.FIFO_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_pc          (if_pc),
      .if_instr       (if_instr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int          n_tests, n_fail, cyc;
   int          rdy_pct, ifr_pct, red_pct, lat_min, lat_max;
   logic [31:0] mem_addr[$];
   int          mem_due[$];
   logic [31:0] exp_pc, pend_t, red_t, force_red_pc;
   bit          pend_t_valid, red_chk, force_red;
   int          n_acc, n_deq, first_acc_cyc, first_deq_cyc, rel_cyc;
   logic [31:0] first_acc_addr, first_deq_pc;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic clear_stats();
      n_acc          = 0;
      n_deq          = 0;
      first_acc_cyc  = -1;
      first_deq_cyc  = -1;
      first_acc_addr = 32'hFFFF_FFFF;
      first_deq_pc   = 32'hFFFF_FFFF;
   endtask

   task automatic drive();
      logic [31:0] r;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if (mem_due.size() > 0 && mem_due[0] <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = memf(mem_addr[0]);
         void'(mem_due.pop_front());
         void'(mem_addr.pop_front());
      end
      imem_req_ready = (int'($urandom_range(99)) < rdy_pct);
      if_ready       = (int'($urandom_range(99)) < ifr_pct);
      r = $urandom();
      if (force_red) begin
         redirect_valid = 1'b1;
         redirect_pc    = force_red_pc;
         force_red      = 1'b0;
      end else begin
         redirect_valid = (int'($urandom_range(99)) < red_pct);
         redirect_pc    = r;
      end
   endtask

   // Architectural stream: consecutive words from the last target; redirects retarget it.
   task automatic observe();
      bit          d;
      logic [31:0] t;
      if (red_chk) begin
         chk_val("redir_if_valid", {31'b0, if_valid}, 32'd0);
         chk_val("redir_addr", imem_req_addr, red_t);
         red_chk = 1'b0;
      end
      d = if_valid && if_ready;
      if (d) begin
         n_deq++;
         if (first_deq_cyc < 0) begin
            first_deq_cyc = cyc;
            first_deq_pc  = if_pc;
         end
         chk_val("deq_pc", if_pc, exp_pc);
         chk_val("deq_instr", if_instr, memf(exp_pc));
         if (pend_t_valid) begin
            exp_pc       = pend_t;
            pend_t_valid = 1'b0;
         end else begin
            exp_pc = exp_pc + 32'd4;
         end
      end
      if (imem_req_valid && imem_req_ready) begin
         n_acc++;
         if (first_acc_cyc < 0) begin
            first_acc_cyc  = cyc;
            first_acc_addr = imem_req_addr;
         end
         mem_addr.push_back(imem_req_addr);
         mem_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
      end
      if (redirect_valid) begin
         t = redirect_pc & 32'hFFFF_FFFC;
`ifdef IFU_DELAY_SLOT_EN
         if (d) begin
            exp_pc       = t;
            pend_t_valid = 1'b0;
         end else begin
            pend_t       = t;
            pend_t_valid = 1'b1;
         end
`else
         exp_pc  = t;
         red_chk = 1'b1;
         red_t   = t;
`endif
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
      drive();
      @(negedge clk);
      observe();
   endtask

   task automatic apply_reset();
      @(posedge clk);
      cyc++;
      #1;
      reset_n        = 1'b0;
      imem_rsp_valid = 1'b0;
      redirect_valid = 1'b0;
      imem_req_ready = 1'b0;
      if_ready       = 1'b0;
      mem_addr.delete();
      mem_due.delete();
      exp_pc       = RST_PC;
      pend_t_valid = 1'b0;
      red_chk      = 1'b0;
      #1;
      chk_val("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      chk_val("rst_if_valid", {31'b0, if_valid}, 32'd0);
      chk_val("rst_if_pc", if_pc, 32'd0);
      chk_val("rst_if_instr", if_instr, 32'd0);
      repeat (2) begin
         @(posedge clk);
         cyc++;
      end
      #1;
      reset_n = 1'b1;
      rel_cyc = cyc;
      drive();
      @(negedge clk);
      chk_val("release_req_idle", {31'b0, imem_req_valid}, 32'd0);
      observe();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int rp[3], ip[3], dp[3], lmx[3];
      n_tests = 0; n_fail = 0; cyc = 0;
      reset_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; if_ready = 1'b0;
      rdy_pct = 100; ifr_pct = 100; red_pct = 0; lat_min = 1; lat_max = 1;
      exp_pc = RST_PC; pend_t_valid = 1'b0; red_chk = 1'b0; force_red = 1'b0;
      force_red_pc = '0; pend_t = '0; red_t = '0;

      // streaming after reset: one request and one delivery per cycle
      clear_stats();
      apply_reset();
      repeat (14) tick();
      chk_val("first_req_addr", first_acc_addr, RST_PC);
      chk_val("first_req_cycle", first_acc_cyc, rel_cyc + 1);
      chk_val("first_deq_cycle", first_deq_cyc, first_acc_cyc + 2);
      chk_val("first_deq_pc", first_deq_pc, RST_PC);
      chk_val("stream_accepts", n_acc, 32'd14);
      chk_val("stream_delivers", n_deq, 32'd12);

      // reset mid-stream with requests outstanding, then decode stalled
      lat_min = 3; lat_max = 3;
      repeat (4) tick();
      ifr_pct = 0; lat_min = 1; lat_max = 1;
      clear_stats();
      apply_reset();
      repeat (6) tick();
      chk_val("stall_first_addr", first_acc_addr, RST_PC);
      chk_val("stall_accepts", n_acc, DEPTH);
      chk_val("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
      chk_val("stall_if_valid", {31'b0, if_valid}, 32'd1);
      chk_val("stall_head_pc", if_pc, RST_PC);

      // 0x3004 buffered, 0x3008 outstanding, redirect to 0x4000
      ifr_pct = 100; lat_min = 3; lat_max = 3;
      tick();
      chk_val("resume_accept", n_acc, DEPTH + 1);
      ifr_pct = 0; lat_min = 1; lat_max = 1;
      force_red = 1'b1; force_red_pc = 32'h0000_4000;
      clear_stats();
      tick();
      ifr_pct = 100;
      repeat (10) tick();
`ifdef IFU_DELAY_SLOT_EN
      chk_val("after_redirect_pc", first_deq_pc, 32'h0000_3004);
`else
      chk_val("after_redirect_pc", first_deq_pc, 32'h0000_4000);
`endif

      // randomized traffic
      rp  = '{70, 40, 100};
      ip  = '{70, 100, 30};
      dp  = '{5, 10, 15};
      lmx = '{4, 2, 3};
      for (int ph = 0; ph < 3; ph++) begin
         rdy_pct = rp[ph]; ifr_pct = ip[ph]; red_pct = dp[ph];
         lat_min = 1; lat_max = lmx[ph];
         repeat (400) tick();
      end

      red_pct = 0; rdy_pct = 100; ifr_pct = 100; lat_min = 1; lat_max = 2;
      clear_stats();
      repeat (40) tick();
      chk_val("drain_progress", {31'b0, (n_deq > 20)}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
